// File: rtl/intc_sequencer.sv
// Interrupt controller: memory-mapped MASK/STATUS/VECTOR registers with an int/int_ack
// handshake sequencer. Define INTC_LEVEL_EN for level-sensitive sources (default: edge).
module intc_sequencer #(
  parameter int NSRC = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            de,
  input  logic            drw,
  input  logic [31:0]     daddr,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic            int_req,
  output logic [31:0]     int_pc,
  input  logic            int_ack
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICING} state_t;

  state_t          state, state_next;
  logic [NSRC:0]   mask;
  logic [NSRC:1]   status;
  logic [31:0]     vector;
  logic [31:0]     rdata;
  logic [NSRC:1]   set_bits;
  logic [NSRC:1]   clr_bits;
  logic [1:0]      sel;
  logic            wr;
  logic            rd;
  logic            pend;
  logic            gie_clr;
  logic            unused_addr;

  assign sel         = daddr[3:2];
  assign wr          = de & drw;
  assign rd          = de & ~drw;
  assign unused_addr = ^{daddr[31:4], daddr[1:0]};
  assign int_pc      = vector;

`ifdef INTC_LEVEL_EN
  assign set_bits = irq;
`else
  logic [NSRC-1:0] irq_prev;

  always_ff @(posedge clk) begin
    if (rst) irq_prev <= '0;
    else     irq_prev <= irq;
  end

  assign set_bits = irq & ~irq_prev;
`endif

  assign clr_bits = (wr && sel == 2'b01) ? din[NSRC:1] : '0;
  assign pend     = mask[0] & (|(status & mask[NSRC:1]));

  always_comb begin
    rdata = '0;
    case (sel)
      2'b00:   rdata = 32'(mask);
      2'b01:   rdata = 32'({status, 1'b0});
      2'b10:   rdata = vector;
      default: rdata = '0;
    endcase
  end

  // Register file; a new capture beats a same-cycle W1C, and the ack auto-clear beats a GIE write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask   <= '0;
      status <= '0;
      vector <= '0;
      dout   <= '0;
    end else begin
      if (wr && sel == 2'b00) mask <= din[NSRC:0];
      if (gie_clr)            mask[0] <= 1'b0;
      status <= (status & ~clr_bits) | set_bits;
      if (wr && sel == 2'b10) vector <= {din[31:2], 2'b00};
      if (rd)                 dout <= rdata;
    end
  end

  // State register; int_req is registered so it is high exactly while in PENDING.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      int_req <= 1'b0;
    end else begin
      state   <= state_next;
      int_req <= (state_next == PENDING);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pend)     state_next = PENDING;
      PENDING:   if (int_ack)  state_next = SERVICING;
      SERVICING: if (!int_ack) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    gie_clr = (state == PENDING) && int_ack;
  end

endmodule

// File: tb/tb_intc_sequencer.sv
// Bench for intc_sequencer: register-access table, handshake sequences and a
// randomized run against a behavioural model.
module tb_intc_sequencer;
  localparam int NSRC = 31;
  localparam logic [32:0] ONE33 = 33'd1;
  localparam logic [31:0] IMPL = 32'((ONE33 << (NSRC + 1)) - ONE33);

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq;
  logic            de, drw, int_ack;
  logic [31:0]     daddr, din;
  logic [31:0]     dout, int_pc;
  logic            int_req;

  int n_chk  = 0;
  int n_fail = 0;

  intc_sequencer #(.NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .irq(irq), .de(de), .drw(drw), .daddr(daddr),
    .din(din), .dout(dout), .int_req(int_req), .int_pc(int_pc), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    de = 1'b1; drw = 1'b1; daddr = a; din = d;
    tick();
    de = 1'b0; drw = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    de = 1'b1; drw = 1'b0; daddr = a;
    tick();
    de = 1'b0;
  endtask

  task automatic do_reset();
    irq = '0; int_ack = 1'b0; de = 1'b0; drw = 1'b0; daddr = '0; din = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model state
  logic [31:0] m_mask, m_status, m_vec, m_dout, m_prev;
  bit          m_req, m_busy;

  task automatic model_step(input logic [NSRC-1:0] i_irq, input logic i_de, input logic i_drw,
                            input logic [31:0] i_addr, input logic [31:0] i_din, input logic i_ack);
    logic [31:0] rdv, setv, clrv, nstat, nmask, nvec, irqv;
    bit          pend;
    case (i_addr[3:2])
      2'd0:    rdv = m_mask;
      2'd1:    rdv = m_status;
      2'd2:    rdv = m_vec;
      default: rdv = 32'd0;
    endcase
    pend = m_mask[0] && ((m_status & m_mask & 32'hFFFF_FFFE) != 0);
    if (i_de && !i_drw) m_dout = rdv;
    irqv = {i_irq, 1'b0};
`ifdef INTC_LEVEL_EN
    setv = irqv;
`else
    setv = irqv & ~m_prev;
`endif
    m_prev = irqv;
    clrv  = (i_de && i_drw && i_addr[3:2] == 2'd1) ? (i_din & 32'hFFFF_FFFE) : 32'd0;
    nstat = ((m_status & ~clrv) | setv) & IMPL & 32'hFFFF_FFFE;
    nmask = (i_de && i_drw && i_addr[3:2] == 2'd0) ? (i_din & IMPL) : m_mask;
    if (m_req && i_ack) nmask[0] = 1'b0;
    nvec = (i_de && i_drw && i_addr[3:2] == 2'd2) ? {i_din[31:2], 2'b00} : m_vec;
    if (m_req) begin
      if (i_ack) begin m_req = 1'b0; m_busy = 1'b1; end
    end else if (m_busy) begin
      if (!i_ack) m_busy = 1'b0;
    end else if (pend) begin
      m_req = 1'b1;
    end
    m_status = nstat; m_mask = nmask; m_vec = nvec;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h0,  32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h4,  32'h0,         32'h0};
    tbl[2]  = '{1'b0, 32'h8,  32'h0,         32'h0};
    tbl[3]  = '{1'b0, 32'hC,  32'h0,         32'h0};
    tbl[4]  = '{1'b1, 32'h8,  32'h0000_1003, 32'h0};
    tbl[5]  = '{1'b0, 32'h8,  32'h0,         32'h0000_1000};
    tbl[6]  = '{1'b1, 32'hC,  32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{1'b0, 32'hC,  32'h0,         32'h0};
    tbl[8]  = '{1'b1, 32'h0,  32'hFFFF_FFFE, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,  32'h0,         32'hFFFF_FFFE};
    tbl[10] = '{1'b1, 32'h4,  32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{1'b0, 32'h4,  32'h0,         32'h0};
    tbl[12] = '{1'b1, 32'h10, 32'h0,         32'h0};
    tbl[13] = '{1'b0, 32'h10, 32'h0,         32'h0};

    do_reset();
    chk("reset_int", 32'(int_req), 32'h0);
    chk("reset_int_pc", int_pc, 32'h0);
    chk("reset_dout", dout, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
      end else begin
        bus_read(tbl[i].addr);
        chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp);
      end
      chk($sformatf("tbl%0d_int", i), 32'(int_req), 32'h0);
    end
    chk("tbl_int_pc", int_pc, 32'h0000_1000);
    tick();
    chk("dout_hold", dout, 32'h0);

    // Edge capture, request raised two edges after the pulse and held without ack
    do_reset();
    bus_write(32'h0, 32'h5);
    irq[1] = 1'b1;
    tick();
    irq[1] = 1'b0;
    chk("pulse_edge1_int", 32'(int_req), 32'h0);
    tick();
    chk("pulse_edge2_int", 32'(int_req), 32'h1);
    bus_read(32'h4);
    chk("status_after_pulse", dout, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("int_hold%0d", i), 32'(int_req), 32'h1);
    end

    // Ack handshake: int drops on the ack edge, GIE auto-clears, back to IDLE after ack drops
    int_ack = 1'b1;
    tick();
    chk("ack_int_fall", 32'(int_req), 32'h0);
    bus_read(32'h0);
    chk("mask_gie_cleared", dout, 32'h4);
    chk("servicing_int", 32'(int_req), 32'h0);
    tick();
    int_ack = 1'b0;
    tick();
    chk("idle_int", 32'(int_req), 32'h0);
    bus_write(32'h0, 32'h5);
    chk("rearm_write_int", 32'(int_req), 32'h0);
    tick();
    chk("rearm_int", 32'(int_req), 32'h1);

    // Ack edge beats a simultaneous software GIE write
    int_ack = 1'b1;
    bus_write(32'h0, 32'h5);
    chk("ack_vs_write_int", 32'(int_req), 32'h0);
    bus_read(32'h0);
    chk("ack_vs_write_mask", dout, 32'h4);
    int_ack = 1'b0;
    tick();

    // Ack while IDLE is ignored
    int_ack = 1'b1;
    tick();
    tick();
    int_ack = 1'b0;
    chk("idle_ack_int", 32'(int_req), 32'h0);
    bus_write(32'h0, 32'h5);
    tick();
    chk("idle_ack_then_rearm", 32'(int_req), 32'h1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();
    bus_write(32'h4, 32'h4);
    bus_read(32'h4);
    chk("w1c_clear", dout, 32'h0);

    // Set wins over a same-cycle W1C
    irq[1] = 1'b1;
    tick();
    irq[1] = 1'b0;
    tick();
    irq[1] = 1'b1;
    bus_write(32'h4, 32'h4);
    irq[1] = 1'b0;
    bus_read(32'h4);
    chk("set_wins", dout, 32'h4);
    bus_write(32'h4, 32'h4);
    bus_read(32'h4);
    chk("w1c_after_set", dout, 32'h0);

`ifdef INTC_LEVEL_EN
    irq[0] = 1'b1;
    tick();
    bus_write(32'h4, 32'h2);
    bus_read(32'h4);
    chk("level_w1c_blocked", dout, 32'h2);
    irq[0] = 1'b0;
    tick();
    bus_write(32'h4, 32'h2);
    bus_read(32'h4);
    chk("level_w1c_clear", dout, 32'h0);
`endif

    // Randomized run against the model
    do_reset();
    m_mask = '0; m_status = '0; m_vec = '0; m_dout = '0; m_prev = '0;
    m_req = 1'b0; m_busy = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [NSRC-1:0] r_irq;
      logic [31:0]     r_addr, r_din;
      logic            r_de, r_drw, r_ack;
      r_irq  = NSRC'($urandom & $urandom & $urandom);
      r_de   = ($urandom_range(0, 2) != 0);
      r_drw  = ($urandom_range(0, 3) == 0);
      r_addr = $urandom;
      r_din  = (($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FF));
      r_ack  = ($urandom_range(0, 2) == 0);
      irq = r_irq; de = r_de; drw = r_drw; daddr = r_addr; din = r_din; int_ack = r_ack;
      model_step(r_irq, r_de, r_drw, r_addr, r_din, r_ack);
      tick();
      chk($sformatf("rnd%0d_int", c), 32'(int_req), 32'(m_req));
      chk($sformatf("rnd%0d_dout", c), dout, m_dout);
      chk($sformatf("rnd%0d_int_pc", c), int_pc, m_vec);
    end
    de = 1'b0; drw = 1'b0; int_ack = 1'b0; irq = '0;

    // Reset mid-sequence forces int low regardless of ack
    bus_write(32'h0, 32'h5);
    irq[1] = 1'b1;
    tick();
    irq[1] = 1'b0;
    tick();
    tick();
    int_ack = 1'b1;
    rst = 1'b1;
    tick();
    chk("reset_mid_int", 32'(int_req), 32'h0);
    rst = 1'b0;
    int_ack = 1'b0;
    tick();
    chk("reset_mid_idle", 32'(int_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
